// File: rtl/ram_responder_pkg.sv
// Shared constants for ram_responder: I/O window location, register offsets
// and status bit positions.
package ram_responder_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [31:0] IO_DATA = 32'd0;
  localparam logic [31:0] IO_STAT = 32'd4;

  localparam int unsigned STAT_TX_FULL  = 0;
  localparam int unsigned STAT_RX_VALID = 1;

endpackage

// File: rtl/ram_responder_byte_fifo.sv
// Circular byte FIFO with wrap-around pointers and an occupancy count.
// Push is ignored when full and pop is ignored when empty.
module byte_fifo
  import ram_responder_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage is not reset, so mask the head while empty to keep dout clean.
  assign dout = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Byte-wide RAM responder with a TX FIFO / status I/O window at IO_BASE.
// Define RX_PATH_EN to add a one-entry RX holding register readable at IO_DATA.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RAM_AW = 17,
  parameter int unsigned TXQ_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_wr_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [7:0]        ram_data_i,
  output logic [7:0]        ram_data_o,
  output logic              rdy_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
`ifdef RX_PATH_EN
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
`endif
  input  logic              tx_ready_i
);

  localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(1) << RAM_AW;

  logic [7:0] r_mem [2**RAM_AW];
  logic [7:0] r_data;

  logic              w_io_sel;
  logic              w_ram_sel;
  logic [ADDR_W-1:0] w_offset;
  logic              w_off_data;
  logic              w_off_stat;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_rx_valid;
  logic [7:0]        w_rx_byte;
  logic [7:0]        w_status;
  logic [7:0]        w_rd_byte;

  assign w_io_sel   = (ram_addr_i[17:16] == 2'b11);
  assign w_ram_sel  = !w_io_sel && (ram_addr_i < RAM_TOP);
  assign w_offset   = ram_addr_i - ADDR_W'(IO_BASE);
  assign w_off_data = w_io_sel && (w_offset == ADDR_W'(IO_DATA));
  assign w_off_stat = w_io_sel && (w_offset == ADDR_W'(IO_STAT));

  // Uses the pre-edge full flag so tx_ready_i never reaches rdy_o.
  assign rdy_o     = !(ram_wr_i && w_off_data && w_tx_full);
  assign w_tx_push = ram_wr_i && w_off_data && !w_tx_full;
  assign w_tx_pop  = tx_valid_o && tx_ready_i;

  assign tx_valid_o = !w_tx_empty;
  assign ram_data_o = r_data;

  byte_fifo #(.AW(TXQ_AW)) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tx_push),
    .din   (ram_data_i),
    .pop   (w_tx_pop),
    .dout  (tx_data_o),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

`ifdef RX_PATH_EN
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic       w_rx_take;

  assign w_rx_take  = !ram_wr_i && w_off_data && r_rx_valid;
  assign rx_ready_o = !r_rx_valid;
  assign w_rx_valid = r_rx_valid;
  assign w_rx_byte  = r_rx_valid ? r_rx_data : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
    end else if (!r_rx_valid && rx_valid_i) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= rx_data_i;
    end else if (w_rx_take) begin
      r_rx_valid <= 1'b0;
    end
  end
`else
  assign w_rx_valid = 1'b0;
  assign w_rx_byte  = 8'h00;
`endif

  always_comb begin
    w_status                = 8'h00;
    w_status[STAT_TX_FULL]  = w_tx_full;
    w_status[STAT_RX_VALID] = w_rx_valid;
  end

  always_comb begin
    w_rd_byte = 8'h00;
    if (w_ram_sel) begin
      w_rd_byte = r_mem[ram_addr_i[RAM_AW-1:0]];
    end else if (w_off_data) begin
      w_rd_byte = w_rx_byte;
    end else if (w_off_stat) begin
      w_rd_byte = w_status;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr_i && w_ram_sel) begin
      r_mem[ram_addr_i[RAM_AW-1:0]] <= ram_data_i;
    end
  end

  // Loads on writes too, giving the old byte on read-during-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= 8'h00;
    end else if (rdy_o) begin
      r_data <= w_rd_byte;
    end
  end

endmodule
